// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
// Bundles the producer/consumer-facing signals of sync_fifo_param.
//   master modport : the block that drives requests and watches status
//   slave modport  : the FIFO itself
// Signals:
//   wr, din          write request and write data
//   rd               read request
//   flush, clr_err   discard contents / clear sticky error flags
//   dout, dout_valid registered read data and its one-cycle valid pulse
//   full, empty, almost_full, almost_empty, level   occupancy status
//   overflow, underflow                             sticky error flags
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              wr;
    logic [DATA_W-1:0] din;
    logic              rd;
    logic              flush;
    logic              clr_err;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, din, rd, flush, clr_err,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr, din, rd, flush, clr_err,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Parametrised single-clock FIFO with fill level, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags. A write into a full FIFO is accepted only when
// a read is accepted in the same cycle, so full-rate pass-through works.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sync_fifo_param_if slave modport (requests in, data/status out)
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sync_fifo_param_if.slave      bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wrPtr_q, wrPtr_d;
    logic [AW-1:0]     rdPtr_q, rdPtr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              doutValid_q, doutValid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              fullFlag;
    logic              emptyFlag;
    logic              rdAcc;
    logic              wrAcc;

    // Status flags are decoded from the level register alone, so nothing on
    // the request inputs can reach a status output combinationally.
    always_comb begin
        fullFlag  = (level_q == LW'(DEPTH));
        emptyFlag = (level_q == '0);
    end

    // Acceptance: a read needs data; a write needs room, or a read in the
    // same cycle that frees the slot it will occupy.
    always_comb begin
        rdAcc = bus.rd && !emptyFlag;
        wrAcc = bus.wr && (!fullFlag || rdAcc);
    end

    // Next-state logic. Flush overrides normal traffic: pointers and level
    // collapse to zero, requests that cycle are dropped without raising an
    // error, and the error flags and last dout are left untouched. When an
    // error and clr_err coincide the error wins because it is applied last.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        level_d     = level_q;
        dout_d      = dout_q;
        doutValid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            if (bus.clr_err) begin
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
            end
            if (bus.wr && !wrAcc) begin
                overflow_d = 1'b1;
            end
            if (bus.rd && !rdAcc) begin
                underflow_d = 1'b1;
            end
            if (wrAcc) begin
                wrPtr_d = wrPtr_q + AW'(1);
            end
            if (rdAcc) begin
                rdPtr_d     = rdPtr_q + AW'(1);
                dout_d      = mem[rdPtr_q];
                doutValid_d = 1'b1;
            end
            case ({wrAcc, rdAcc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Control and output registers; reset clears everything except memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, never cleared. When reading and writing the same slot
    // in one cycle the read above sampled the old word before this update.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && wrAcc) begin
            mem[wrPtr_q] <= bus.din;
        end
    end

    // Drive the interface outputs from registers and level decodes.
    always_comb begin
        bus.dout         = dout_q;
        bus.dout_valid   = doutValid_q;
        bus.full         = fullFlag;
        bus.empty        = emptyFlag;
        bus.almost_full  = (level_q >= LW'(AF_LEVEL));
        bus.almost_empty = (level_q <= LW'(AE_LEVEL));
        bus.level        = level_q;
        bus.overflow     = overflow_q;
        bus.underflow    = underflow_q;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16). A queue
// based reference model tracks contents, last read word and error flags;
// every cycle all DUT outputs are compared against it.
module tb_sync_fifo_param;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int errorCount = 0;
    int checkCount = 0;

    logic [7:0] modelQ[$];
    logic [7:0] modelDout = 8'h00;
    bit         modelDv   = 1'b0;
    bit         modelOv   = 1'b0;
    bit         modelUn   = 1'b0;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Count a comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of requests, advance the model by the FIFO's rules,
    // clock the DUT and compare every output against the model.
    task automatic applyStimulus(input bit wrIn, input logic [7:0] dinIn,
                                 input bit rdIn, input bit flushIn,
                                 input bit clrIn, input bit rstIn);
        bit rdOk;
        bit wrOk;
        rst         = rstIn;
        bus.wr      = wrIn;
        bus.din     = dinIn;
        bus.rd      = rdIn;
        bus.flush   = flushIn;
        bus.clr_err = clrIn;

        if (rstIn) begin
            modelQ.delete();
            modelDout = 8'h00;
            modelDv   = 1'b0;
            modelOv   = 1'b0;
            modelUn   = 1'b0;
        end else if (flushIn) begin
            modelQ.delete();
            modelDv = 1'b0;
        end else begin
            rdOk = rdIn && (modelQ.size() > 0);
            wrOk = wrIn && ((modelQ.size() < DEPTH) || rdOk);
            if (clrIn) begin
                modelOv = 1'b0;
                modelUn = 1'b0;
            end
            if (wrIn && !wrOk) modelOv = 1'b1;
            if (rdIn && !rdOk) modelUn = 1'b1;
            modelDv = rdOk;
            if (rdOk) modelDout = modelQ.pop_front();
            if (wrOk) modelQ.push_back(dinIn);
        end

        @(posedge clk);
        #1;
        checkOutput("level",        32'(bus.level),        32'(modelQ.size()));
        checkOutput("full",         32'(bus.full),         32'(modelQ.size() == DEPTH));
        checkOutput("empty",        32'(bus.empty),        32'(modelQ.size() == 0));
        checkOutput("almost_full",  32'(bus.almost_full),  32'(modelQ.size() >= AF_LEVEL));
        checkOutput("almost_empty", 32'(bus.almost_empty), 32'(modelQ.size() <= AE_LEVEL));
        checkOutput("dout",         32'(bus.dout),         32'(modelDout));
        checkOutput("dout_valid",   32'(bus.dout_valid),   32'(modelDv));
        checkOutput("overflow",     32'(bus.overflow),     32'(modelOv));
        checkOutput("underflow",    32'(bus.underflow),    32'(modelUn));
    endtask

    // Directed scenarios followed by a randomized soak.
    initial begin
        bus.wr      = 1'b0;
        bus.din     = 8'h00;
        bus.rd      = 1'b0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;

        // Reset, with a write and read asserted that must be discarded.
        applyStimulus(1, 8'hEE, 1, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);

        // Fill with 0x00..0x0F, then drain in order.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'(i), 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);

        // Overflow on full, then clear it.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 8'($urandom), 0, 0, 0, 0);
        applyStimulus(1, 8'hAA, 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1, 0);

        // Drain, underflow on empty, then write alongside a rejected read.
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(1, 8'h55, 1, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1, 0);

        // Pass-through at full for 20 cycles.
        while (bus.level < 5'(DEPTH)) applyStimulus(1, 8'($urandom), 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(1, 8'h77, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);

        // Pointer wrap with bursts of 5 writes and 3 reads.
        for (int i = 0; i < 40; i++) begin
            if ((i % 8) < 5) applyStimulus(1, 8'($urandom), 0, 0, 0, 0);
            else             applyStimulus(0, 8'h00, 1, 0, 0, 0);
        end

        // Flush at level 9 with an error flag set; requests that cycle ignored.
        applyStimulus(0, 8'h00, 0, 1, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(1, 8'($urandom), 0, 0, 0, 0);
        applyStimulus(1, 8'hC3, 1, 1, 1, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        applyStimulus(1, 8'h3C, 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 0, 0, 0);

        // Reset at level 7 with both error flags set.
        applyStimulus(0, 8'h00, 1, 0, 0, 0);
        while (bus.level < 5'(DEPTH)) applyStimulus(1, 8'($urandom), 0, 0, 0, 0);
        applyStimulus(1, 8'h99, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) applyStimulus(0, 8'h00, 1, 0, 0, 0);
        applyStimulus(1, 8'h12, 1, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);

        // Randomized soak, including rare flush/clear/reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 55, 8'($urandom),
                          $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 5,
                          $urandom_range(0, 99) < 1);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
